// File: rtl/keycode_event_gen_pkg.sv
// Shared types for the keycode event generator: event encoding, FSM states
// and the 10-bit event record stored in the FIFO.
package keycode_pkg;

  typedef enum logic [1:0] {
    EV_PRESS   = 2'd0,
    EV_RELEASE = 2'd1,
    EV_REPEAT  = 2'd2
  } ev_type_t;

  localparam logic [7:0] KEY_NONE = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_RPT   = 2'd2
  } state_t;

  typedef struct packed {
    ev_type_t   ev_type;
    logic [7:0] code;
  } key_event_t;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/keycode_event_gen_if.sv
// Valid/ready pop interface carrying the head of the key event queue.
interface keycode_event_gen_if;
  import keycode_pkg::*;

  logic       ev_valid;
  logic [7:0] ev_code;
  ev_type_t   ev_type;
  logic       ev_ready;

  modport master (output ev_valid, output ev_code, output ev_type, input ev_ready);
  modport slave  (input ev_valid, input ev_code, input ev_type, output ev_ready);
endinterface

// File: rtl/keycode_ev_fifo.sv
// Show-ahead event FIFO: up to two ordered pushes and one pop per cycle,
// reports free slots including the slot released by this cycle's pop.
module keycode_ev_fifo
  import keycode_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push0,
  input  key_event_t               din0,
  input  logic                     push1,
  input  key_event_t               din1,
  input  logic                     pop,
  output logic                     valid,
  output key_event_t               dout,
  output logic [$clog2(DEPTH):0]   free
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);

  key_event_t     mem [DEPTH];
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  wr_ptr1;
  logic [AW:0]    count;
  logic           pop_en;

  assign valid   = (count != '0);
  assign pop_en  = pop && valid;
  assign dout    = valid ? mem[rd_ptr] : '0;
  assign free    = DEPTH_V - count + (AW+1)'(pop_en);
  assign wr_ptr1 = wr_ptr + AW'(push0);

  always_ff @(posedge clk) begin
    if (push0) mem[wr_ptr]  <= din0;
    if (push1) mem[wr_ptr1] <= din1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push0) + AW'(push1);
      if (pop_en) rd_ptr <= rd_ptr + AW'(1);
      count  <= count + (AW+1)'(push0) + (AW+1)'(push1) - (AW+1)'(pop_en);
    end
  end
endmodule

// File: rtl/keycode_event_gen.sv
// Turns the level keycode from the PIO into queued PRESS/RELEASE/REPEAT
// events with typematic auto-repeat and a sticky overflow flag.
module keycode_event_gen
  import keycode_pkg::*;
#(
  parameter int unsigned REPEAT_DELAY  = 50,
  parameter int unsigned REPEAT_PERIOD = 10,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [7:0]                 keycode_i,
  keycode_event_gen_if.master        ev,
  output logic [7:0]                 held_key,
  input  logic                       ovf_clr,
  output logic                       overflow
);
  localparam int unsigned CW = $clog2(max2(REPEAT_DELAY, REPEAT_PERIOD));
  localparam int unsigned FW = $clog2(FIFO_DEPTH) + 1;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [7:0]    held_nx;
  logic          push0, push1, ovf_set, rpt_fire;
  key_event_t    ev0, ev1, head;
  logic [FW-1:0] free;
  logic          fifo_valid, pop;

  assign pop         = fifo_valid && ev.ev_ready;
  assign ev.ev_valid = fifo_valid;
  assign ev.ev_code  = head.code;
  assign ev.ev_type  = head.ev_type;

  keycode_ev_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push0 (push0),
    .din0  (ev0),
    .push1 (push1),
    .din1  (ev1),
    .pop   (pop),
    .valid (fifo_valid),
    .dout  (head),
    .free  (free)
  );

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    held_nx  = held_key;
    push0    = 1'b0;
    push1    = 1'b0;
    ovf_set  = 1'b0;
    rpt_fire = 1'b0;
    ev0      = '0;
    ev1      = '0;
    if (keycode_i != held_key) begin
      held_nx  = keycode_i;
      cnt_nx   = '0;
      state_nx = (keycode_i != KEY_NONE) ? ST_DELAY : ST_IDLE;
      if (held_key != KEY_NONE && keycode_i != KEY_NONE) begin
        // Switch: RELEASE takes the first slot so it survives a one-slot shortage.
        ev0     = '{ev_type: EV_RELEASE, code: held_key};
        ev1     = '{ev_type: EV_PRESS,   code: keycode_i};
        push0   = (free != '0);
        push1   = (free >= FW'(2));
        ovf_set = (free < FW'(2));
      end else begin
        if (held_key != KEY_NONE) ev0 = '{ev_type: EV_RELEASE, code: held_key};
        else                      ev0 = '{ev_type: EV_PRESS,   code: keycode_i};
        push0   = (free != '0);
        ovf_set = (free == '0);
      end
    end else begin
      case (state)
        ST_DELAY: begin
          if (cnt == CW'(REPEAT_DELAY - 1)) begin
            rpt_fire = 1'b1;
            cnt_nx   = '0;
            state_nx = ST_RPT;
          end else cnt_nx = cnt + CW'(1);
        end
        ST_RPT: begin
          if (cnt == CW'(REPEAT_PERIOD - 1)) begin
            rpt_fire = 1'b1;
            cnt_nx   = '0;
          end else cnt_nx = cnt + CW'(1);
        end
        default: ;
      endcase
      if (rpt_fire) begin
        ev0   = '{ev_type: EV_REPEAT, code: held_key};
        push0 = (free != '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      held_key <= KEY_NONE;
      overflow <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      held_key <= held_nx;
      if (ovf_set)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end
endmodule

// File: tb/tb_keycode_event_gen.sv
// Bench for keycode_event_gen: directed scenarios plus random stimulus,
// checked every cycle against a queue-based model of the event stream.
module tb_keycode_event_gen;
  localparam int RD = 8;
  localparam int RP = 4;
  localparam int DEPTH = 4;

  logic       clk;
  logic       reset;
  logic [7:0] kc;
  logic       rdy;
  logic       clr;
  logic [7:0] held_key;
  logic       overflow;

  keycode_event_gen_if evif ();
  assign evif.ev_ready = rdy;

  keycode_event_gen #(.REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .keycode_i (kc),
    .ev        (evif),
    .held_key  (held_key),
    .ovf_clr   (clr),
    .overflow  (overflow)
  );

  int total = 0;
  int bad = 0;
  int ncyc = 0;
  int rpt_pops = 0;

  // model: queue entries are {type[1:0], code[7:0]}
  logic [9:0] q[$];
  logic [7:0] m_held;
  int         m_age;
  logic       m_ovf;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: events derived from keycode changes and hold age.
  always @(posedge clk) begin
    int free;
    logic set;
    ncyc++;
    if (reset) begin
      q.delete();
      m_held = 8'h00;
      m_age  = 0;
      m_ovf  = 1'b0;
    end else begin
      if (q.size() > 0 && rdy) void'(q.pop_front());
      free = DEPTH - q.size();
      set  = 1'b0;
      if (kc != m_held) begin
        if (m_held != 8'h00) begin
          if (free > 0) begin q.push_back({2'd1, m_held}); free--; end
          else set = 1'b1;
        end
        if (kc != 8'h00) begin
          if (free > 0) begin q.push_back({2'd0, kc}); free--; end
          else set = 1'b1;
        end
        m_held = kc;
        m_age  = 0;
      end else if (m_held != 8'h00) begin
        m_age++;
        if (m_age >= RD && (m_age - RD) % RP == 0 && free > 0)
          q.push_back({2'd2, m_held});
      end
      if (set)      m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (ncyc > 0) begin
      chk("ev_valid", int'(evif.ev_valid), int'(q.size() > 0));
      if (q.size() > 0) begin
        chk("ev_code", int'(evif.ev_code), int'(q[0][7:0]));
        chk("ev_type", int'(evif.ev_type), int'(q[0][9:8]));
      end
      chk("held_key", int'(held_key), int'(m_held));
      chk("overflow", int'(overflow), int'(m_ovf));
      if (evif.ev_valid && rdy && evif.ev_type == keycode_pkg::EV_REPEAT) rpt_pops++;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int snap;
    reset = 1'b1; kc = 8'h00; rdy = 1'b1; clr = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(2);
    chk("rst_valid", int'(evif.ev_valid), 0);
    chk("rst_held", int'(held_key), 0);
    chk("rst_ovf", int'(overflow), 0);

    // press/hold/release of 0x1A
    snap = rpt_pops;
    kc = 8'h1A;
    tick();
    chk("press_valid", int'(evif.ev_valid), 1);
    chk("press_code", int'(evif.ev_code), 8'h1A);
    chk("press_type", int'(evif.ev_type), 0);
    chk("press_held", int'(held_key), 8'h1A);
    tick(20);
    kc = 8'h00;
    tick();
    chk("release_code", int'(evif.ev_code), 8'h1A);
    chk("release_type", int'(evif.ev_type), 1);
    tick(3);
    chk("repeat_count", rpt_pops - snap, 4);
    chk("idle_held", int'(held_key), 0);

    // direct switch 0x04 -> 0x07
    kc = 8'h04;
    tick(4);
    kc = 8'h07;
    tick();
    chk("sw_rel_code", int'(evif.ev_code), 8'h04);
    chk("sw_rel_type", int'(evif.ev_type), 1);
    tick();
    chk("sw_prs_code", int'(evif.ev_code), 8'h07);
    chk("sw_prs_type", int'(evif.ev_type), 0);
    tick(10);
    kc = 8'h00;
    tick(4);

    // overflow on switch with one slot free, silent repeat drops, clear
    rdy = 1'b0;
    kc = 8'h2C; tick();
    kc = 8'h00; tick();
    kc = 8'h2C; tick();
    kc = 8'h16; tick();
    chk("ovf_set", int'(overflow), 1);
    tick(15);
    chk("ovf_hold", int'(overflow), 1);
    chk("full_head_code", int'(evif.ev_code), 8'h2C);
    chk("full_head_type", int'(evif.ev_type), 0);
    clr = 1'b1; tick();
    clr = 1'b0;
    chk("ovf_clr", int'(overflow), 0);
    rdy = 1'b1; kc = 8'h00; tick();
    chk("full_pop_push_ovf", int'(overflow), 0);
    chk("full_pop_push_valid", int'(evif.ev_valid), 1);
    tick(6);

    // reset with queued events while 0x1A is held
    rdy = 1'b0;
    kc = 8'h1A; tick();
    kc = 8'h00; tick();
    kc = 8'h1A; tick();
    reset = 1'b1; tick();
    chk("rst_mid_valid", int'(evif.ev_valid), 0);
    chk("rst_mid_held", int'(held_key), 0);
    reset = 1'b0; tick();
    chk("rst_repress_code", int'(evif.ev_code), 8'h1A);
    chk("rst_repress_type", int'(evif.ev_type), 0);
    chk("rst_repress_held", int'(held_key), 8'h1A);
    tick(2);
    rdy = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        case ($urandom_range(0, 4))
          0: kc = 8'h00;
          1: kc = 8'h1A;
          2: kc = 8'h2C;
          3: kc = 8'h04;
          default: kc = 8'h07;
        endcase
      end
      if (((i / 200) % 2) == 1) rdy = ($urandom_range(0, 3) == 0);
      else                      rdy = ($urandom_range(0, 3) != 0);
      clr   = ($urandom_range(0, 19) == 0);
      reset = ($urandom_range(0, 299) == 0);
      tick();
    end
    reset = 1'b0; clr = 1'b0;
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1);
  end
endmodule
